// File: rtl/multiplier_seq_if.sv
// Operand, result and handshake bundle between the MULT-DIV issue logic and the
// shift-add multiplier.
interface multiplier_seq_if #(
   parameter int LENGTH = 32
) ();
   logic [LENGTH-1:0] oper_a;
   logic [LENGTH-1:0] oper_b;
   logic [1:0]        fuct3;
   logic              enable_mul;
   logic [LENGTH-1:0] mul_o;
   logic              mul_finish;
   logic              mul_busy;

   modport master (
      output oper_a, oper_b, fuct3, enable_mul,
      input  mul_o, mul_finish, mul_busy
   );

   modport slave (
      input  oper_a, oper_b, fuct3, enable_mul,
      output mul_o, mul_finish, mul_busy
   );
endinterface

// File: rtl/multiplier_seq.sv
// Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU. Works on operand
// magnitudes and applies the product sign in a final FIX cycle.
module multiplier_seq #(
   parameter int LENGTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   multiplier_seq_if.slave  bus
);
   localparam int CW = $clog2(LENGTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [LENGTH-1:0]   a_mag_q, a_mag_d;
   logic                neg_q, neg_d;
   logic [1:0]          f3_q, f3_d;
   logic [2*LENGTH:0]   acc_q, acc_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [LENGTH-1:0]   mul_o_q, mul_o_d;
   logic                finish_q, finish_d;
   logic                busy_q, busy_d;

   logic                sign_a_s, sign_b_s;
   logic [LENGTH-1:0]   mag_a_s, mag_b_s;
   logic [LENGTH:0]     sum_s;
   logic [2*LENGTH:0]   add_s;
   logic [2*LENGTH-1:0] prod_s;

   // Next-state, datapath and output computation
   always_comb begin
      state_d  = state_q;
      a_mag_d  = a_mag_q;
      neg_d    = neg_q;
      f3_d     = f3_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      mul_o_d  = mul_o_q;
      finish_d = 1'b0;

      // a is unsigned only for MULHU; b is signed only for MUL and MULH
      sign_a_s = (bus.fuct3 != 2'b11) & bus.oper_a[LENGTH-1];
      sign_b_s = (bus.fuct3[1] == 1'b0) & bus.oper_b[LENGTH-1];
      mag_a_s  = sign_a_s ? (~bus.oper_a + LENGTH'(1)) : bus.oper_a;
      mag_b_s  = sign_b_s ? (~bus.oper_b + LENGTH'(1)) : bus.oper_b;

      sum_s  = acc_q[2*LENGTH:LENGTH] + {1'b0, a_mag_q};
      add_s  = acc_q[0] ? {sum_s, acc_q[LENGTH-1:0]} : acc_q;
      prod_s = neg_q ? (~acc_q[2*LENGTH-1:0] + (2*LENGTH)'(1)) : acc_q[2*LENGTH-1:0];

      case (state_q)
         IDLE: begin
            if (bus.enable_mul) begin
               state_d = BUSY;
               a_mag_d = mag_a_s;
               neg_d   = sign_a_s ^ sign_b_s;
               f3_d    = bus.fuct3;
               acc_d   = {(LENGTH+1)'(0), mag_b_s};
               cnt_d   = CW'(0);
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            acc_d = {1'b0, add_s[2*LENGTH:1]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(LENGTH - 1)) begin
               state_d = FIX;
            end else begin
               state_d = BUSY;
            end
         end
         FIX: begin
            mul_o_d  = (f3_q == 2'b00) ? prod_s[LENGTH-1:0] : prod_s[2*LENGTH-1:LENGTH];
            finish_d = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_mag_q  <= '0;
         neg_q    <= 1'b0;
         f3_q     <= 2'b00;
         acc_q    <= '0;
         cnt_q    <= '0;
         mul_o_q  <= '0;
         finish_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_mag_q  <= a_mag_d;
         neg_q    <= neg_d;
         f3_q     <= f3_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         mul_o_q  <= mul_o_d;
         finish_q <= finish_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.mul_o      = mul_o_q;
   assign bus.mul_finish = finish_q;
   assign bus.mul_busy   = busy_q;
endmodule

// File: doc/multiplier_seq.md
# multiplier_seq

Iterative shift-add multiplier for the RV32IM M-extension multiply instructions (MUL, MULH, MULHSU, MULHU). It sits beside the division unit in the MULT-DIV execution path and uses the same operand, funct3 and enable/finish naming. A single start pulse launches a fixed-latency operation. The selected 32-bit half of the 64-bit product is returned with a one-cycle finish strobe.

## Interface
- length, 32, operand and result width
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- oper_a  in  length  multiplicand (rs1)
- oper_b  in  length  multiplier (rs2)
- fuct3  in  2  funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- enable_mul  in  1  start request; sampled only in IDLE
- mul_o  out  length  result; held until the next completion
- mul_finish  out  1  one-cycle pulse; mul_o is valid in this cycle
- mul_busy  out  1  high while an operation is in flight

## Operation
- States:
  - IDLE -> BUSY when enable_mul=1.
  - BUSY -> FIX after length iterations.
  - FIX -> IDLE unconditionally.
- Start edge (IDLE, enable_mul=1):
  - Latch oper_a, oper_b and fuct3.
  - Signedness: a is signed for MUL, MULH and MULHSU; b is signed for MUL and MULH only.
  - Store magnitudes |a| and |b|. A signed operand is negated if its MSB is set; an unsigned operand is used as-is.
  - neg = sign_a XOR sign_b, where the sign of an unsigned operand is 0.
  - Clear the 2*length+1-bit accumulator; load |b| into its low half.
  - Clear the iteration counter (6 bits for length=32).
- BUSY, one iteration per cycle:
  - If the accumulator LSB is 1, add |a| into the upper length+1 bits.
  - Shift the whole accumulator right by 1.
  - Increment the counter; after iteration length-1, go to FIX.
- FIX:
  - prod = neg ? two's complement of the 2*length-bit accumulator : accumulator.
  - mul_o <= prod[length-1:0] for MUL, otherwise prod[2*length-1:length].
  - mul_finish <= 1.
- mul_finish drops the following cycle. mul_o keeps its value until the next FIX.
- The 0x80000000 magnitude is handled correctly as unsigned 2^31, since the magnitude path is length bits unsigned.
- There is no zero-operand shortcut; latency is always fixed.
- Division by zero has no analogue here; all operand values are legal.

## Timing
- Reset values:
  - state IDLE
  - mul_o 0
  - mul_finish 0
  - mul_busy 0
  - counter and accumulator 0
- Latency: with the start edge as E0, mul_finish is high in the cycle after edge E(length+1), which is E33 for length=32.
- mul_busy = (state != IDLE). It is high from after E0 through E(length+1) and low in the mul_finish cycle.
- Back-to-back: enable_mul=1 during the mul_finish cycle is accepted, since the state is IDLE. That result appears 33 edges later.
- enable_mul during BUSY or FIX is ignored; there is no queueing.
- Operand or fuct3 changes after E0 have no effect on the operation in flight.
- Reset during BUSY or FIX:
  - The operation is aborted and the state returns to IDLE.
  - mul_o is cleared to 0 and no mul_finish is produced.
  - A start on the first edge after reset is released is accepted.
- rst has priority over enable_mul on the same edge.

## Test plan
- MUL 7×3, one enable pulse:
  - mul_busy rises after E0.
  - mul_finish pulses exactly after E33 with mul_o=0x00000015.
  - mul_busy is low in the same cycle.
- Signed MUL and MULH, -7×3:
  - MUL gives 0xFFFFFFEB.
  - MULH gives 0xFFFFFFFF.
  - MUL -7×-3 gives 0x00000015 and MULH gives 0x00000000.
- Unsigned/mixed cases:
  - MULHU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFE; MUL on the same operands gives 0x00000001.
  - MULHSU 0xFFFFFFFF(-1)×0xFFFFFFFF gives 0xFFFFFFFF.
- Corner case: MULH 0x80000000×0x80000000 gives 0x40000000; MUL on the same operands gives 0x00000000.
- Handshake:
  - Hold enable_mul high continuously with changing operands: starts occur only at E0, E34 and E68.
  - Operand changes mid-flight do not alter results.
  - mul_finish is never high for 2 consecutive cycles.
- Reset:
  - Assert rst at iteration 10 of 3025×12: no mul_finish; mul_o=0 and mul_busy=0 after the reset edge.
  - A restart of 18×6 returns 0x0000006C after 33 edges.
